// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Purpose
//   8-bit asynchronous serial transmitter. A byte is sent LSB first with one
//   start bit (0) and one stop bit (1). An optional parity bit goes between
//   the last data bit and the stop bit. Every bit lasts CLKS_PER_BIT clocks.
//   A request presented while a frame is in flight is dropped, not queued.
//
// Configuration
//   UART_TX_PARITY_EN  define to add the parity bit (11-bit frames).
//                      Leave undefined for 10-bit frames with no parity
//                      logic. PARITY_ODD then has no effect.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit, 2..65535 (default 16)
//   PARITY_ODD    0 = even parity, 1 = odd parity (default 0)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   data_in     in   [7:0] byte to send, sampled only on acceptance
//   data_valid  in   transmit request, qualifies data_in
//   busy        out  high while a frame is in progress, registered
//   tx_out      out  serial line, idles high, registered
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       tx_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    // Illegal configurations stop elaboration rather than producing a
    // counter that never reaches its bit-end value.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
    end

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    // The last clock of the current bit. Every state advances on this event.
    logic bit_end;
    assign bit_end = (cnt_q == LAST_CNT);

    // tx_q and busy_q are loaded together with state_q on each transition,
    // so both outputs come straight from flops and stay aligned with the
    // state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shift register and parity flop are reset along with
            // the control state. A reset then leaves the whole datapath in a
            // known value, so nothing from an aborted frame can resurface.
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: all state updates here are non-blocking. Each branch
            // therefore reads the values from before this edge, such as
            // shift_q[1] during the shift.
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (data_valid) begin
                        shift_q <= data_in;
                        idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
                        // Computed from the byte as accepted. The shift
                        // register is consumed while the data bits go out.
                        par_q   <= (^data_in) ^ 1'(PARITY_ODD);
`endif
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // The bit that shift_q[0] will hold after this
                            // edge.
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Bench for uart_tx. It uses two instances:
//   dut4  CLKS_PER_BIT=4, even parity. A frame-level model checks it.
//   dut2  CLKS_PER_BIT=2, odd parity. Directed checks only.
// Define UART_TX_PARITY_EN for the bench and the RTL together.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int N4 = 4;
    localparam int N2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid4 = 1'b0;
    logic       valid2 = 1'b0;
    logic       busy4, tx4, busy2, tx2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N4), .PARITY_ODD(0)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (valid4),
        .busy       (busy4),
        .tx_out     (tx4)
    );

    uart_tx #(.CLKS_PER_BIT(N2), .PARITY_ODD(1)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (valid2),
        .busy       (busy2),
        .tx_out     (tx2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model of dut4 ----------------
    // Bit j of the frame for byte b: start, 8 data LSB first, parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int j, input int odd);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NB == 11 && j == 9) return 1'(($countones(b) + odd) % 2);
        return 1'b1;
    endfunction

    // One {tx, busy} entry per expected clock cycle. The trailing idle entry
    // accounts for the mandatory IDLE cycle before the next acceptance.
    logic [1:0] exp_q[$];

    always @(posedge clk) begin
        if (reset && valid4 && exp_q.size() == 0) begin
            for (int j = 0; j < NB; j++)
                for (int c = 0; c < N4; c++)
                    exp_q.push_back({frame_bit(data_in, j, 0), 1'b1});
            exp_q.push_back(2'b10);
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] e;
        if (!reset) begin
            exp_q.delete();
            e = 2'b10;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 2'b10;
        end
        check("model tx_out", 32'(tx4), 32'(e[1]));
        check("model busy", 32'(busy4), 32'(e[0]));
    end

    // ---------------- directed helpers ----------------
    logic cap_tx [0:63];
    logic cap_busy [0:63];

    task automatic send(input bit sel, input logic [7:0] b);
        data_in = b;
        if (sel) valid2 = 1'b1; else valid4 = 1'b1;
        @(posedge clk);
        #2;
        valid4 = 1'b0;
        valid2 = 1'b0;
    endtask

    // Call right after send(). Sample k lies in the k-th cycle after acceptance.
    task automatic check_frame(input bit sel, input int n, input logic [0:10] seq, input string name);
        int last;
        int bc;
        last = NB * n + 1;
        bc = 0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            cap_tx[k]   = sel ? tx2 : tx4;
            cap_busy[k] = sel ? busy2 : busy4;
        end
        for (int j = 0; j < NB; j++)
            for (int c = 0; c < n; c++)
                check($sformatf("%s bit%0d cyc%0d", name, j, c), 32'(cap_tx[j*n+c+1]), 32'(seq[j]));
        for (int k = 1; k < last; k++) if (cap_busy[k] === 1'b1) bc++;
        check({name, " busy cycles"}, bc, NB * n);
        check({name, " gap tx_out"}, 32'(cap_tx[last]), 1);
        check({name, " gap busy"}, 32'(cap_busy[last]), 0);
    endtask

    task automatic wait_busy4(input logic level, input int bound, input string name);
        int i;
        i = 0;
        while (1) begin
            @(negedge clk);
            if (busy4 === level) return;
            i++;
            if (i > bound) begin
                check({name, " timeout"}, 32'(busy4), 32'(level));
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:10] seq;
        int lr;
        int gap;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset tx4", 32'(tx4), 1);
        check("reset busy4", 32'(busy4), 0);
        check("reset tx2", 32'(tx2), 1);
        check("reset busy2", 32'(busy2), 0);

        // Release reset and request on the same cycle. This is accepted on
        // the first edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        send(0, 8'hA5);
`ifdef UART_TX_PARITY_EN
        seq = 11'b01010010101;
`else
        seq = {10'b0101001011, 1'b0};
`endif
        check_frame(0, N4, seq, "a5");

`ifdef UART_TX_PARITY_EN
        // Even parity on dut4, odd parity on dut2.
        send(0, 8'h07);
        seq = 11'b01110000011;
        check_frame(0, N4, seq, "07 even");
        send(1, 8'h07);
        seq = 11'b01110000001;
        check_frame(1, N2, seq, "07 odd");
`endif

        // CLKS_PER_BIT=2 boundary: 8'h00 gives 18 low cycles.
        send(1, 8'h00);
`ifdef UART_TX_PARITY_EN
        seq = 11'b00000000011;
`else
        seq = {10'b0000000001, 1'b0};
`endif
        check_frame(1, N2, seq, "00 n2");
        lr = 0;
        for (int k = 1; k <= 40; k++) begin
            if (cap_tx[k] !== 1'b0) break;
            lr++;
        end
        check("00 n2 low run", lr, 18);

        // A request during DATA is ignored.
        send(0, 8'hFF);
        repeat (10) @(posedge clk);
        #2;
        data_in = 8'h3C;
        valid4 = 1'b1;
        @(posedge clk);
        #2;
        valid4 = 1'b0;
        wait_busy4(1'b0, 60, "ff frame end");
        repeat (3) @(negedge clk);
        check("no queued frame busy", 32'(busy4), 0);
        check("no queued frame tx", 32'(tx4), 1);

        // data_valid held high: back-to-back frames with one IDLE cycle between.
        data_in = 8'h55;
        valid4 = 1'b1;
        wait_busy4(1'b1, 5, "b2b start");
        wait_busy4(1'b0, 60, "b2b first end");
        check("b2b gap tx", 32'(tx4), 1);
        gap = 1;
        while (1) begin
            @(negedge clk);
            if (busy4 === 1'b1 || gap > 10) break;
            gap++;
        end
        check("b2b gap cycles", gap, 1);
        valid4 = 1'b0;
        wait_busy4(1'b0, 60, "b2b second end");
        @(negedge clk);

        // Reset during data bit 3 aborts the frame without waiting for a clock.
        send(0, 8'hC3);
        repeat (18) @(posedge clk);
        #1;
        check("pre-abort busy", 32'(busy4), 1);
        reset = 1'b0;
        #1;
        check("abort tx_out", 32'(tx4), 1);
        check("abort busy", 32'(busy4), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        send(0, 8'h81);
`ifdef UART_TX_PARITY_EN
        seq = 11'b01000000101;
`else
        seq = {10'b0100000011, 1'b0};
`endif
        check_frame(0, N4, seq, "81 after reset");

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter: PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-003 Port: clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: data_in  input  8  byte to transmit; sampled only on acceptance.
REQ-006 Port: data_valid  input  1  transmit request; qualifies data_in.
REQ-007 Port: busy  output  1  high while a frame is in progress.
REQ-008 Port: tx_out  output  1  serial line; idles high; registered output.

Function
REQ-009 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with exactly one state active at any time.
REQ-010 Acceptance SHALL occur at a rising edge where state==IDLE and data_valid==1: data_in latched into the shift register, the baud counter cleared, bit index cleared, next state START.
REQ-011 data_valid outside IDLE SHALL be ignored, with no queuing and no corruption of the frame in flight.
REQ-012 busy SHALL be 1 in every state except IDLE, so it rises in the cycle after acceptance.
REQ-013 The baud counter SHALL count 0..CLKS_PER_BIT-1; the bit-end event is counter==CLKS_PER_BIT-1, at which point the counter wraps to 0.
REQ-014 Each bit (start, data, parity, stop) SHALL drive tx_out for exactly CLKS_PER_BIT clock cycles.
REQ-015 In START, tx_out SHALL be 0; at the bit-end event the next state is DATA.
REQ-016 In DATA, tx_out SHALL be shift_reg[0], LSB first; at each bit-end event the shift register shifts right by one and the 3-bit index increments.
REQ-017 At the bit-end event with index==7, the next state SHALL be PARITY if UART_TX_PARITY_EN is defined, else STOP.
REQ-018 In PARITY, tx_out SHALL be the XOR of the latched byte, XORed with PARITY_ODD; the parity value is computed at acceptance, not from the shifting register.
REQ-019 In STOP, tx_out SHALL be 1; at the bit-end event the next state is IDLE.
REQ-020 A new acceptance is possible in the first IDLE cycle after STOP, giving a minimum inter-frame gap of 1 clock beyond the stop bit.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity, measured from the first cycle tx_out==0.
REQ-022 tx_out SHALL go low on the clock edge following acceptance, giving a latency of 1 cycle.
REQ-023 In IDLE, tx_out SHALL be 1 and the baud counter SHALL be held at 0.

Reset
REQ-024 When reset==0, the block SHALL asynchronously force: state=IDLE, tx_out=1, busy=0, baud counter=0, bit index=0, shift register=8'h00, parity bit=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with tx_out returning high without waiting for a clock; no partial frame resumes after reset release.
REQ-026 After reset deassertion, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-027 The macro UART_TX_PARITY_EN defined SHALL compile in the PARITY state and the parity register, making frames 11 bits long.
REQ-028 With UART_TX_PARITY_EN undefined, no parity logic SHALL exist, PARITY_ODD SHALL have no effect, and frames SHALL be 10 bits: start, 8 data, stop.

Verification
REQ-029 Use CLKS_PER_BIT=4 with no parity; send 8'hA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, with each bit 4 cycles long; busy high for 40 cycles.
REQ-030 With UART_TX_PARITY_EN defined and PARITY_ODD=0, send 8'h07 -> parity bit 1; with PARITY_ODD=1, send 8'h07 -> parity bit 0; frame is 44 cycles.
REQ-031 Pulse data_valid with 8'h3C during the DATA state of an 8'hFF frame -> transmitted byte stays 8'hFF and 8'h3C is never sent.
REQ-032 Hold data_valid high continuously with data_in=8'h55 -> back-to-back frames with exactly 1 IDLE cycle (tx_out=1, busy=0) between stop and start.
REQ-033 Assert reset during DATA bit 3 -> tx_out=1 and busy=0 before the next clock edge; after release, 8'h81 transmits correctly.
REQ-034 Use CLKS_PER_BIT=2 boundary; send 8'h00 -> tx_out low for 18 cycles, then high for 2 cycles.
